// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: four-digit BCD countdown timer with load/start/pause control and optional auto-reload
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   tick     in   decrement strobe, honoured only while running
//   load     in   latch load_val into count and reload registers (rejected if not BCD)
//   load_val in   16 four BCD digits, [15:12] most significant
//   start    in   begin, resume or restart counting
//   pause    in   suspend counting
//   digits   out  16 current count
//   running  out  high while counting
//   done     out  one-cycle pulse when the count expires
//   err      out  sticky: last load attempt had a non-BCD digit
module bcd_countdown_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] reload_q, reload_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    function automatic logic is_bcd(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) ok = ok & (v[4*i +: 4] <= 4'd9);
        return ok;
    endfunction

    // Ripple borrow from the least significant digit; a 0 digit wraps to 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Strict priority: the highest asserted command is the only one considered,
    // even when it has no effect in the current state.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        err_d    = err_q;
        if (load) begin
            if (is_bcd(load_val)) begin
                count_d  = load_val;
                reload_d = load_val;
                err_d    = 1'b0;
                state_d  = ST_IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else if (pause) begin
            if (state_q == ST_RUN) state_d = ST_PAUSED;
        end else if (start) begin
            if (state_q == ST_IDLE && count_q != 16'h0000) state_d = ST_RUN;
            else if (state_q == ST_PAUSED) state_d = ST_RUN;
            else if (state_q == ST_DONE) begin
                count_d = reload_q;
                state_d = (reload_q != 16'h0000) ? ST_RUN : ST_DONE;
            end
        end else if (tick && state_q == ST_RUN && count_q != 16'h0000) begin
            if (count_q == 16'h0001) begin
                done_d  = 1'b1;
                count_d = AUTO_RELOAD ? reload_q : 16'h0000;
                state_d = (AUTO_RELOAD && reload_q != 16'h0000) ? ST_RUN : ST_DONE;
            end else begin
                count_d = bcd_dec(count_q);
            end
        end
    end

    assign digits  = count_q;
    assign running = (state_q == ST_RUN);
    assign done    = done_q;
    assign err     = err_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed vector table plus multi-cycle sequences for both reload modes
module tb_bcd_countdown_timer;
    logic        clk = 1'b0;
    logic        rst, tick, load, start, pause;
    logic [15:0] load_val;
    logic [15:0] digits0, digits1;
    logic        running0, running1, done0, done1, err0, err1;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .digits(digits0), .running(running0),
        .done(done0), .err(err0)
    );

    bcd_countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .digits(digits1), .running(running1),
        .done(done1), .err(err1)
    );

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        st;
        logic        pa;
        logic        tk;
        logic [15:0] e_dig;
        logic        e_run;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t tbl[30];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic l, input logic [15:0] lv, input logic s, input logic p, input logic t);
        load = l;
        load_val = lv;
        start = s;
        pause = p;
        tick = t;
    endtask

    task automatic step(input logic l, input logic [15:0] lv, input logic s, input logic p, input logic t);
        set_in(l, lv, s, p, t);
        @(negedge clk);
    endtask

    task automatic do_reset;
        set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0999, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0999, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0998, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h12A4, 1'b0, 1'b0, 1'b0, 16'h0998, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0997, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0};
        tbl[25] = '{1'b1, 16'h0009, 1'b1, 1'b1, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0};
        tbl[26] = '{1'b1, 16'h999A, 1'b0, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b1};
        tbl[27] = '{1'b1, 16'h0A00, 1'b1, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b1};
        tbl[28] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0009, 1'b1, 1'b0, 1'b1};
        tbl[29] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b1};

        rst = 1'b0;
        set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("reset digits", digits0, 16'h0000);
        check("reset running", {15'd0, running0}, 16'd0);
        check("reset done", {15'd0, done0}, 16'd0);
        check("reset err", {15'd0, err0}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].pa, tbl[i].tk);
            check($sformatf("vec%0d digits", i), digits0, tbl[i].e_dig);
            check($sformatf("vec%0d running", i), {15'd0, running0}, {15'd0, tbl[i].e_run});
            check($sformatf("vec%0d done", i), {15'd0, done0}, {15'd0, tbl[i].e_done});
            check($sformatf("vec%0d err", i), {15'd0, err0}, {15'd0, tbl[i].e_err});
        end

        do_reset();
        step(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("borrow 0100->0099", digits0, 16'h0099);
        repeat (98) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("countdown at 0001", digits0, 16'h0001);
        check("no early done", {15'd0, done0}, 16'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("expire digits", digits0, 16'h0000);
        check("expire done", {15'd0, done0}, 16'd1);
        check("expire running", {15'd0, running0}, 16'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("done one cycle", {15'd0, done0}, 16'd0);
        check("no underflow", digits0, 16'h0000);

        do_reset();
        step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("ar first tick", digits1, 16'h0001);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("ar reload digits", digits1, 16'h0002);
        check("ar done", {15'd0, done1}, 16'd1);
        check("ar running", {15'd0, running1}, 16'd1);
        check("nonar stops", {15'd0, running0}, 16'd0);
        check("nonar done", {15'd0, done0}, 16'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("ar done pulse ends", {15'd0, done1}, 16'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("ar second run", digits1, 16'h0001);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("ar second done", {15'd0, done1}, 16'd1);
        check("ar second reload", digits1, 16'h0002);

        do_reset();
        step(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h00A0, 1'b0, 1'b0, 1'b0);
        check("run at 0050", digits0, 16'h0050);
        check("bad load keeps run", {15'd0, running0}, 16'd1);
        check("bad load err", {15'd0, err0}, 16'd1);
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async rst digits", digits0, 16'h0000);
        check("async rst running", {15'd0, running0}, 16'd0);
        check("async rst err", {15'd0, err0}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("no done after rst", {15'd0, done0}, 16'd0);
            check("idle after rst", digits0, 16'h0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter: AUTO_RELOAD, 0, when 1 the timer reloads from the reload register on reaching zero and keeps running.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: tick  input  1  one-cycle count-enable strobe (decrement request).
REQ-005 Port: load  input  1  latch load_val into count and reload registers.
REQ-006 Port: load_val  input  16  four BCD digits; [15:12] most significant, [3:0] least significant.
REQ-007 Port: start  input  1  begin or resume counting.
REQ-008 Port: pause  input  1  suspend counting.
REQ-009 Port: digits  output  16  current count, four BCD digits, registered.
REQ-010 Port: running  output  1  high exactly while in RUN.
REQ-011 Port: done  output  1  one-cycle pulse when count reaches 0000 from RUN.
REQ-012 Port: err  output  1  sticky flag: last load attempt carried an invalid BCD digit.

Function
REQ-013 The block SHALL implement states IDLE, RUN, PAUSED, DONE.
REQ-014 Command priority SHALL be load > pause > start > tick in every state.
REQ-015 Load with all nibbles <= 9: count and reload SHALL take load_val at the next edge, err SHALL clear, state SHALL become IDLE.
REQ-016 Load with any nibble > 9: count, reload and state SHALL be unchanged; err SHALL set.
REQ-017 IDLE + start with count != 0000 -> RUN; IDLE + start with count == 0000 -> stay IDLE, no done.
REQ-018 RUN + pause -> PAUSED, no decrement that cycle even if tick high.
REQ-019 PAUSED + start -> RUN; count unchanged on the transition.
REQ-020 DONE + start -> count := reload, state RUN if reload != 0000, else stay DONE.
REQ-021 tick SHALL be ignored in IDLE, PAUSED and DONE.
REQ-022 RUN + tick: count SHALL decrement by one in BCD at that edge (latency 1 clock): a digit at 0 becomes 9 and borrows from the next digit; all other digits hold.
REQ-023 RUN + tick with count == 0001 (i.e. result 0000): AUTO_RELOAD=0 -> count 0000, state DONE; AUTO_RELOAD=1 -> count := reload, stay RUN.
REQ-024 done SHALL be high for exactly the one cycle following the edge that completes REQ-023, in both AUTO_RELOAD modes.
REQ-025 Count SHALL never underflow; 0000 is never decremented.
REQ-026 digits SHALL always hold four valid BCD digits.
REQ-027 A held start or pause level SHALL behave as the same command repeated each cycle (no edge detection inside the block).

Reset
REQ-028 On rst high, immediately and independent of clk: digits = 0000, reload = 0000, state IDLE, running = 0, done = 0, err = 0.
REQ-029 rst asserted mid-count SHALL abandon the count; no done pulse SHALL be produced by or after the reset.
REQ-030 First command after rst deassertion SHALL be honoured at the first following rising edge.

Verification
REQ-031 Load 0x0100, start, 1 tick -> digits 0x0099; 99 more ticks -> digits 0x0000, done one cycle, running 0, state DONE.
REQ-032 Load 0x1000, start, 1 tick -> digits 0x0999 (triple borrow); tick + pause same cycle -> no decrement, PAUSED; start -> RUN, next tick -> 0x0998.
REQ-033 Load 0x12A4 -> err 1, digits unchanged; then load 0x0003 -> err 0, digits 0x0003.
REQ-034 AUTO_RELOAD=1, load 0x0002, start, 2 ticks -> done pulse, digits 0x0002, running stays 1; 2 more ticks -> second done pulse.
REQ-035 Load 0x0000, start -> stays IDLE, running 0, no done; load + start + tick same cycle -> load wins, IDLE.
REQ-036 In RUN at 0x0050, assert rst between clock edges -> digits 0x0000, running 0 immediately; no done afterwards.
